conv_sched_12x12: RTL and testbench
===================================

// Module: conv_sched_12x12
// PURPOSE
//  Sequencer for the 12-row x 3-tap PE convolution array. It loads an 18-bit kernel at start.
//  It accepts a 12x12 image one 12-pixel column at a time over a valid/ready stream.
//  It keeps a 3-column sliding window and drives the array's 288-bit window input.
//  After the PE latency it captures each 200-bit output column and emits it on a valid/ready
//  result stream. One frame gives 10 result columns (res_col 0..9).
// PARAMETERS
//  PIX_W   8   pixel width; window row = 3*PIX_W = 24 bits
//  N_ROWS  12  image rows; array window width = N_ROWS*3*PIX_W = 288
//  N_COLS  12  image columns per frame; result columns = N_COLS-2 = 10
//  FILT_W  18  kernel width (3 rows x 3 taps x 2 bits)
//  OUT_W   200 array output width (10 x 20 bits), passed through unmodified
//  PE_LAT  1   array latency in clk edges from arr_in change to arr_out valid (>=1)
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    asynchronous, active-high reset
//  start       in   1    frame start pulse; sampled only in IDLE
//  cfg_filter  in   18   kernel; captured into arr_filter on the accepted start
//  busy        out  1    high from the accepted start until done
//  done        out  1    one-cycle pulse at end of frame
//  col_valid   in   1    input column valid
//  col_ready   out  1    input column ready
//  col_data    in   96   column; row r pixel = col_data[8r+:8]
//  arr_in      out  288  window to array; row r = arr_in[24r+:24] = {col c+2, col c+1, col c}
//  arr_filter  out  18   registered kernel to array
//  arr_out     in   200  array result column
//  res_valid   out  1    result valid
//  res_ready   in   1    result ready
//  res_data    out  200  registered copy of arr_out
//  res_col     out  4    result column index 0..9
// BEHAVIOUR
//  Reset: every output and internal register is 0 (arr_in, arr_filter, res_data, res_col,
//   res_valid, col_ready, busy, done). FSM goes to IDLE. Applies immediately, mid-frame too.
//   The partial frame is discarded and no done pulse is issued.
//  FSM states: IDLE, FILL, LOAD, WAIT, OUT, FIN.
//  IDLE: col_ready=0. start=1 latches cfg_filter into arr_filter, sets busy, clears the column
//   counter and res_col, and goes to FILL.
//  FILL: col_ready=1. Each accepted column (col_valid&col_ready) shifts into the window.
//   After 2 columns go to LOAD.
//  LOAD: col_ready=1. On acceptance: shift the window and go to WAIT with the wait counter = 0.
//  Window shift per row r: row <= {col_data[8r+:8], row[23:16], row[15:8]}.
//   The oldest column leaves from bits [7:0].
//  WAIT: col_ready=0; arr_in is held. Counts PE_LAT edges, then captures arr_out into
//   res_data and sets res_valid (OUT).
//   Result: res_valid rises at edge T+PE_LAT+1, where T is the accepting edge.
//  OUT: res_valid, res_data and res_col are held stable until res_valid&res_ready.
//   On that handshake res_valid falls next edge. If res_col==9, go to FIN.
//   Otherwise res_col increments and the FSM goes to LOAD.
//  FIN: done=1 for exactly one cycle, busy falls on the same edge, then IDLE.
//   arr_in and arr_filter keep their last values.
//  start outside IDLE is ignored. cfg_filter changes outside the accepted start have no effect.
//  No column is accepted in IDLE, WAIT, OUT or FIN. Exactly 12 columns are consumed per frame.
//  col_valid may drop at any time; bubbles only stall the FSM.
//  res_ready may be held low indefinitely; there is no timeout and no data loss.
//  No arithmetic is done here. Output sum width and overflow belong to the array.
//  Throughput: one result every PE_LAT+3 cycles at best (accept, wait, capture, handshake).
// TESTING
//  1 Reset: assert rst mid-WAIT -> all outputs 0 in the same cycle; IDLE; col_ready=0.
//  2 Full frame: filter=18'h15555, column c pixels all = c+1, valid/ready always high.
//    -> exactly 10 results with res_col 0..9.
//    -> for res_col 0 each arr_in row = 24'h030201; for res_col 9 each row = 24'h0C0B0A.
//    -> res_data matches the behavioural array model; done pulses once and busy falls.
//  3 Backpressure: hold res_ready low 5 cycles at res_col 3.
//    -> res_valid, res_data and res_col stay stable; col_ready=0 throughout.
//  4 Input bubbles: col_valid random at 30% duty -> results identical to test 2.
//  5 start=1 and cfg_filter=18'h3FFFF during busy -> arr_filter unchanged; frame unaffected.
//  6 rst after 5 results, then a new frame -> 10 fresh results from res_col 0; no stale data.

Source files
------------

// File: rtl/conv_sched_12x12.sv
// Sequencer for the 12-row x 3-tap PE convolution array.
// Loads the kernel on start, builds a 3-column sliding window from a streamed
// 12x12 image, waits out the array latency and returns each output column on a
// valid/ready result stream (10 result columns per frame).
module conv_sched_12x12 #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned N_ROWS = 12,
    parameter int unsigned N_COLS = 12,
    parameter int unsigned FILT_W = 18,
    parameter int unsigned OUT_W  = 200,
    parameter int unsigned PE_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [FILT_W-1:0]             cfg_filter,
    output logic                          busy,
    output logic                          done,
    input  logic                          col_valid,
    output logic                          col_ready,
    input  logic [N_ROWS*PIX_W-1:0]       col_data,
    output logic [N_ROWS*3*PIX_W-1:0]     arr_in,
    output logic [FILT_W-1:0]             arr_filter,
    input  logic [OUT_W-1:0]              arr_out,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [OUT_W-1:0]              res_data,
    output logic [3:0]                    res_col
);

    localparam int unsigned ROW_W = 3 * PIX_W;
    localparam int unsigned WIN_W = N_ROWS * ROW_W;
    localparam int unsigned RES_W = 4;
    localparam int unsigned LAT_W = (PE_LAT < 2) ? 1 : $clog2(PE_LAT + 1);
    localparam logic [RES_W-1:0] LAST_COL = RES_W'(N_COLS - 3);
    localparam logic [LAT_W-1:0] LAT_END  = LAT_W'(PE_LAT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILL = 3'd1,
        S_LOAD = 3'd2,
        S_WAIT = 3'd3,
        S_OUT  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             fill_cnt;
    logic [LAT_W-1:0] wait_cnt;
    logic             col_acc;
    logic             col_ready_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             start_acc;
    logic             shift_en;
    logic             capture;
    logic             res_hs;
    logic [WIN_W-1:0] win_shift;

    assign col_acc = col_valid & col_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_FILL;
            S_FILL: if (col_acc && fill_cnt) state_nxt = S_LOAD;
            S_LOAD: if (col_acc) state_nxt = S_WAIT;
            S_WAIT: if (wait_cnt == LAT_END) state_nxt = S_OUT;
            S_OUT:  if (res_valid && res_ready) begin
                        state_nxt = (res_col == LAST_COL) ? S_FIN : S_LOAD;
                    end
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output/strobe decode; handshake outputs are registered from the next state
    always_comb begin
        col_ready_nxt = 1'b0;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        start_acc     = 1'b0;
        shift_en      = 1'b0;
        capture       = 1'b0;
        res_hs        = 1'b0;
        col_ready_nxt = (state_nxt == S_FILL) || (state_nxt == S_LOAD);
        busy_nxt      = (state_nxt != S_IDLE) && (state_nxt != S_FIN);
        done_nxt      = (state_nxt == S_FIN);
        start_acc     = (state == S_IDLE) && start;
        shift_en      = col_acc && ((state == S_FILL) || (state == S_LOAD));
        capture       = (state == S_WAIT) && (wait_cnt == LAT_END);
        res_hs        = (state == S_OUT) && res_valid && res_ready;
    end

    // Window with the new column entering at the top of every row
    always_comb begin
        win_shift = arr_in;
        for (int r = 0; r < int'(N_ROWS); r++) begin
            win_shift[ROW_W*r +: ROW_W] = {col_data[PIX_W*r +: PIX_W],
                                           arr_in[ROW_W*r + PIX_W +: 2*PIX_W]};
        end
    end

    // Fill and latency counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_cnt <= 1'b0;
            wait_cnt <= '0;
        end else begin
            if (start_acc) begin
                fill_cnt <= 1'b0;
            end else if (shift_en && (state == S_FILL)) begin
                fill_cnt <= 1'b1;
            end
            if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + LAT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_ready  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            arr_in     <= '0;
            arr_filter <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_col    <= '0;
        end else begin
            col_ready <= col_ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            if (start_acc) begin
                arr_filter <= cfg_filter;
                res_col    <= '0;
            end else if (res_hs && (res_col != LAST_COL)) begin
                res_col <= res_col + RES_W'(1);
            end
            if (shift_en) begin
                arr_in <= win_shift;
            end
            if (capture) begin
                res_data  <= arr_out;
                res_valid <= 1'b1;
            end else if (res_hs) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_sched_12x12.sv
// Self-checking bench for conv_sched_12x12 with a registered behavioural array model.
module tb_conv_sched_12x12;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [17:0]    cfg_filter;
    logic           busy;
    logic           done;
    logic           col_valid;
    logic           col_ready;
    logic [95:0]    col_data;
    logic [287:0]   arr_in;
    logic [17:0]    arr_filter;
    logic [199:0]   arr_out;
    logic           res_valid;
    logic           res_ready;
    logic [199:0]   res_data;
    logic [3:0]     res_col;

    typedef struct {
        logic [3:0]   col;
        logic [287:0] win;
        logic [199:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  img [12][12];
    logic [17:0] cur_filt;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    bit          stop_drv;

    conv_sched_12x12 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_filter (cfg_filter),
        .busy       (busy),
        .done       (done),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .col_data   (col_data),
        .arr_in     (arr_in),
        .arr_filter (arr_filter),
        .arr_out    (arr_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_col    (res_col)
    );

    always #5 clk = ~clk;

    // Array model: out row i = sum over 3x3 taps of pixel * 2-bit weight
    function automatic logic [199:0] arr_model(input logic [287:0] w, input logic [17:0] f);
        logic [199:0] o;
        logic [19:0]  s;
        o = '0;
        for (int i = 0; i < 10; i++) begin
            s = '0;
            for (int kr = 0; kr < 3; kr++) begin
                for (int t = 0; t < 3; t++) begin
                    s = s + 20'(w[24*(i+kr) + 8*t +: 8]) * 20'(f[2*(3*kr+t) +: 2]);
                end
            end
            o[20*i +: 20] = s;
        end
        return o;
    endfunction

    // One-edge latency from arr_in to arr_out
    always @(posedge clk) arr_out <= arr_model(arr_in, arr_filter);

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] col_word(input int c);
        logic [95:0] w;
        w = '0;
        if (c < 12) for (int r = 0; r < 12; r++) w[8*r +: 8] = img[c][r];
        return w;
    endfunction

    function automatic logic [287:0] win_of(input int k);
        logic [287:0] w;
        for (int r = 0; r < 12; r++) w[24*r +: 24] = {img[k+2][r], img[k+1][r], img[k][r]};
        return w;
    endfunction

    task automatic fill_img(input bit rnd);
        for (int c = 0; c < 12; c++)
            for (int r = 0; r < 12; r++)
                img[c][r] = rnd ? 8'($urandom_range(255)) : 8'(c + 1);
    endtask

    // Column driver; pushes the expected result when a window's last column is accepted
    task automatic drive(input int duty, input bit noisy);
        int   c;
        bit   acc;
        exp_t e;
        c = 0;
        col_valid = 1'b0;
        while (c < 12 && !stop_drv) begin
            @(negedge clk);
            acc = col_valid && col_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                if (c >= 2) begin
                    e.col  = 4'(c - 2);
                    e.win  = win_of(c - 2);
                    e.data = arr_model(e.win, cur_filt);
                    sb.push_back(e);
                end
                c++;
            end
            if (noisy && c >= 5 && c < 9) begin
                start = 1'b1;
                cfg_filter = 18'h3FFFF;
            end else begin
                start = 1'b0;
            end
            col_valid = (c < 12) && ($urandom_range(99) < duty);
            col_data  = col_word(c);
        end
        col_valid = 1'b0;
        start = 1'b0;
    endtask

    // Result monitor with optional 5-cycle backpressure at column bp_col
    task automatic collect(input int n_res, input int bp_col);
        int           got;
        int           cyc;
        int           hold;
        bit           fresh;
        logic [199:0] hd;
        logic [3:0]   hc;
        exp_t         e;
        got = 0; cyc = 0; hold = 0; fresh = 1'b1; hd = '0; hc = '0;
        res_ready = 1'b1;
        while (got < n_res && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (res_valid) begin
                if (fresh) begin
                    fresh = 1'b0;
                    if (sb.size() == 0) begin
                        check("sb_size", 288'(sb.size()), 288'd1);
                    end else begin
                        e = sb.pop_front();
                        check("res_col", 288'(res_col), 288'(e.col));
                        check("arr_in", arr_in, e.win);
                        check("res_data", 288'(res_data), 288'(e.data));
                        check("arr_filter", 288'(arr_filter), 288'(cur_filt));
                        check("busy_mid", 288'(busy), 288'd1);
                    end
                    hd = res_data;
                    hc = res_col;
                    hold = (int'(res_col) == bp_col) ? 5 : 0;
                end else begin
                    check("hold_data", 288'(res_data), 288'(hd));
                    check("hold_col", 288'(res_col), 288'(hc));
                    check("hold_col_ready", 288'(col_ready), 288'd0);
                end
                if (hold > 0) begin
                    res_ready = 1'b0;
                    hold--;
                end else begin
                    res_ready = 1'b1;
                    got++;
                    fresh = 1'b1;
                end
            end else if (!fresh) begin
                check("hold_valid", 288'(res_valid), 288'd1);
                fresh = 1'b1;
            end
        end
        if (got < n_res) check("res_timeout", 288'(got), 288'(n_res));
    endtask

    task automatic run_frame(input logic [17:0] filt, input int duty, input int bp_col,
                             input bit noisy, input int n_res);
        int base;
        base = done_cnt;
        stop_drv = 1'b0;
        cur_filt = filt;
        @(negedge clk);
        cfg_filter = filt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_filter = 18'($urandom_range(262143));
        fork
            drive(duty, noisy);
            begin
                collect(n_res, bp_col);
                stop_drv = 1'b1;
            end
        join
        if (n_res == 10) begin
            repeat (4) @(negedge clk);
            check("done_count", 288'(done_cnt - base), 288'd1);
            check("busy_end", 288'(busy), 288'd0);
            check("sb_left", 288'(sb.size()), 288'd0);
            check("filter_kept", 288'(arr_filter), 288'(filt));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_arr_in"}, arr_in, 288'd0);
        check({tag, "_arr_filter"}, 288'(arr_filter), 288'd0);
        check({tag, "_res_data"}, 288'(res_data), 288'd0);
        check({tag, "_res_col"}, 288'(res_col), 288'd0);
        check({tag, "_res_valid"}, 288'(res_valid), 288'd0);
        check({tag, "_col_ready"}, 288'(col_ready), 288'd0);
        check({tag, "_busy"}, 288'(busy), 288'd0);
        check({tag, "_done"}, 288'(done), 288'd0);
    endtask

    initial begin
        int n;
        int cyc;
        int base;
        rst = 1'b1; start = 1'b0; cfg_filter = '0; col_valid = 1'b0;
        col_data = '0; res_ready = 1'b0; stop_drv = 1'b0; cur_filt = '0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;

        // Reset asserted while waiting on the array
        fill_img(1'b0);
        @(negedge clk);
        cfg_filter = 18'h15555; start = 1'b1; col_valid = 1'b1; col_data = col_word(0);
        @(negedge clk);
        start = 1'b0;
        n = 0; cyc = 0;
        while (n < 3 && cyc < 20) begin
            if (col_ready) n++;
            @(negedge clk);
            cyc++;
        end
        check("t1_wait_col_ready", 288'(col_ready), 288'd0);
        check("t1_busy", 288'(busy), 288'd1);
        #1 rst = 1'b1;
        #1 check_zero("t1");
        col_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t1_idle_col_ready", 288'(col_ready), 288'd0);

        // Full frame, backpressure, input bubbles, start noise during busy
        run_frame(18'h15555, 100, -1, 1'b0, 10);
        run_frame(18'h15555, 100, 3, 1'b0, 10);
        run_frame(18'h15555, 30, -1, 1'b0, 10);
        run_frame(18'h15555, 100, -1, 1'b1, 10);

        // Reset after five results, then a fresh frame with new data
        fill_img(1'b1);
        base = done_cnt;
        run_frame(18'h0A5C3, 100, -1, 1'b0, 5);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check_zero("t6");
        repeat (4) @(negedge clk);
        check("t6_no_done", 288'(done_cnt - base), 288'd0);
        fill_img(1'b1);
        run_frame(18'h2D3C9, 100, -1, 1'b0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
